// File: rtl/lamp_pkg.sv
// lamp_pkg: shared light-bus types for the traffic controller, the lamp driver
// and their benches.
//   light_t : 2-bit light code (GREEN/YELLOW/RED; 2'b11 is illegal)
//   state_t : lamp driver states (RUN, FAULT)
//   fault_t : latched fault cause codes
package lamp_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FLT_ILLEGAL   = 2'd0,
        FLT_CONFLICT  = 2'd1,
        FLT_SKIP_YEL  = 2'd2,
        FLT_SHORT_YEL = 2'd3
    } fault_t;

    // The one code value with no light_t member
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    function automatic logic is_red(input logic [1:0] code);
        return code == RED;
    endfunction

endpackage

// File: rtl/lamp_dir_check.sv
// lamp_dir_check: per-direction front end of the lamp driver.
// Registers the incoming light code, counts how long the registered code
// has been YELLOW, and flags unsafe transitions of the incoming code.
// Ports:
//   clk       in  1  clock, rising edge
//   reset     in  1  synchronous, active-low
//   code      in  2  light code from the controller
//   clr_cnt   in  1  clear the yellow counter (FAULT exit)
//   code_q    out 2  registered light code
//   illegal   out 1  incoming code is 2'b11
//   skip_yel  out 1  incoming RED while registered code is GREEN
//   short_yel out 1  incoming RED after fewer than MIN_YEL yellow cycles
module lamp_dir_check
    import lamp_pkg::*;
#(
    parameter int MIN_YEL = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] code,
    input  logic       clr_cnt,
    output logic [1:0] code_q,
    output logic       illegal,
    output logic       skip_yel,
    output logic       short_yel
);

    localparam int CW = $clog2(MIN_YEL + 1);

    if (MIN_YEL < 1) begin : g_bad_min_yel
        $error("lamp_dir_check: MIN_YEL must be at least 1");
    end

    // yel_cnt equals the number of cycles code_q has shown YELLOW so far,
    // including the current one, saturating at MIN_YEL.
    logic [CW-1:0] yel_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            code_q  <= RED;
            yel_cnt <= '0;
        end else begin
            code_q <= code;
            if (clr_cnt || code != YELLOW) begin
                yel_cnt <= '0;
            end else if (yel_cnt != CW'(MIN_YEL)) begin
                yel_cnt <= yel_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        illegal   = (code == CODE_ILLEGAL);
        skip_yel  = is_red(code) && (code_q == GREEN);
        short_yel = is_red(code) && (code_q == YELLOW) && (yel_cnt < CW'(MIN_YEL));
    end

endmodule

// File: rtl/lamp_driver.sv
// lamp_driver: receiving end of the traffic controller light bus.
// Decodes la/lb into lamp outputs with one cycle of latency and acts as an
// independent safety monitor: any illegal or unsafe pattern latches FAULT,
// which forces both directions to red until fault_clr is given with both
// buses showing RED.
// Optional feature macro: LAMP_FLASH_EN -- red lamps flash in FAULT with a
// half-period of FLASH_HALF cycles; otherwise they are steady on.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  synchronous, active-low
//   la, lb     in  2  street A / B light codes
//   fault_clr  in  1  leave FAULT (only when la == lb == RED)
//   a_grn/a_yel/a_red, b_grn/b_yel/b_red  out 1  lamp drives
//   fault      out 1  high while in FAULT
//   fault_code out 2  cause of the latched fault
module lamp_driver
    import lamp_pkg::*;
#(
    parameter int MIN_YEL    = 5,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] la,
    input  logic [1:0] lb,
    input  logic       fault_clr,
    output logic       a_grn,
    output logic       a_yel,
    output logic       a_red,
    output logic       b_grn,
    output logic       b_yel,
    output logic       b_red,
    output logic       fault,
    output logic [1:0] fault_code
);

    if (FLASH_HALF < 1) begin : g_bad_flash_half
        $error("lamp_driver: FLASH_HALF must be at least 1");
    end

    state_t     state;
    logic [1:0] la_q, lb_q;
    logic       a_illegal, a_skip, a_short;
    logic       b_illegal, b_skip, b_short;
    logic       conflict;
    logic       hit;
    fault_t     hit_code;
    logic       exit_ok;
    logic       red_fault;

    assign exit_ok = (state == FAULT) && fault_clr && is_red(la) && is_red(lb);

    lamp_dir_check #(.MIN_YEL(MIN_YEL)) u_dir_a (
        .clk       (clk),
        .reset     (reset),
        .code      (la),
        .clr_cnt   (exit_ok),
        .code_q    (la_q),
        .illegal   (a_illegal),
        .skip_yel  (a_skip),
        .short_yel (a_short)
    );

    lamp_dir_check #(.MIN_YEL(MIN_YEL)) u_dir_b (
        .clk       (clk),
        .reset     (reset),
        .code      (lb),
        .clr_cnt   (exit_ok),
        .code_q    (lb_q),
        .illegal   (b_illegal),
        .skip_yel  (b_skip),
        .short_yel (b_short)
    );

    assign conflict = !is_red(la) && !is_red(lb);

    // Priority encode; A/B order within a class does not change the code.
    always_comb begin
        hit      = 1'b1;
        hit_code = FLT_ILLEGAL;
        if (a_illegal || b_illegal) begin
            hit_code = FLT_ILLEGAL;
        end else if (conflict) begin
            hit_code = FLT_CONFLICT;
        end else if (a_skip || b_skip) begin
            hit_code = FLT_SKIP_YEL;
        end else if (a_short || b_short) begin
            hit_code = FLT_SHORT_YEL;
        end else begin
            hit = 1'b0;
        end
    end

    // The offending code is captured into la_q/lb_q on the same edge that
    // enters FAULT, so the decode below never displays it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            fault      <= 1'b0;
            fault_code <= FLT_ILLEGAL;
        end else begin
            case (state)
                RUN: begin
                    if (hit) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= hit_code;
                    end
                end
                FAULT: begin
                    if (exit_ok) begin
                        state <= RUN;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

`ifdef LAMP_FLASH_EN
    localparam int FW = $clog2(FLASH_HALF + 1);

    logic [FW-1:0] flash_cnt;
    logic          flash_on;

    // Held at its start value throughout RUN so FAULT always begins lit.
    always_ff @(posedge clk) begin
        if (!reset || state == RUN) begin
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
            flash_cnt <= '0;
            flash_on  <= !flash_on;
        end else begin
            flash_cnt <= flash_cnt + 1'b1;
        end
    end

    assign red_fault = flash_on;
`else
    assign red_fault = 1'b1;
`endif

    always_comb begin
        a_grn = 1'b0;
        a_yel = 1'b0;
        a_red = 1'b0;
        b_grn = 1'b0;
        b_yel = 1'b0;
        b_red = 1'b0;
        if (state == FAULT) begin
            a_red = red_fault;
            b_red = red_fault;
        end else begin
            a_grn = (la_q == GREEN);
            a_yel = (la_q == YELLOW);
            a_red = (la_q == RED);
            b_grn = (lb_q == GREEN);
            b_yel = (lb_q == YELLOW);
            b_red = (lb_q == RED);
        end
    end

endmodule
